mdu_iter: RTL
=============

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 32 bits.
REQ-002 clk  in  1  rising-edge clock, the single clock domain.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  in  32  rs1 operand, from register-file rd1.
REQ-007 b  in  32  rs2 operand, from register-file rd2.
REQ-008 rd  in  5  destination register index.
REQ-009 flush  in  1  synchronous abort.
REQ-010 busy  out  1  high in CALC and DONE; core stalls while high.
REQ-011 wb_we  out  1  register-file write enable, one-cycle pulse.
REQ-012 wb_wa  out  5  register-file write address.
REQ-013 wb_wd  out  32  register-file write data.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 IDLE with start=1 SHALL capture op, a, b and rd at the clock edge.
  - Special case (REQ-021/022) -> DONE.
  - Otherwise -> CALC with iteration counter=0.
REQ-016 CALC SHALL perform one iteration per cycle for exactly 32 cycles, then go to DONE.
  - Multiply: shift-add.
  - Divide: restoring.
REQ-017 DONE SHALL last one cycle with wb_we=1, wb_wa=captured rd and wb_wd=result, then -> IDLE.
REQ-018 Latency: normal ops SHALL assert wb_we in the 34th cycle after the start edge (33 edges); special cases SHALL assert it in the 2nd cycle.
REQ-019 Multiply SHALL operate on magnitudes and negate the 64-bit product when the effective signs differ.
  - Signedness: MUL/MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned.
  - MUL returns product[31:0]; the others return product[63:32].
REQ-020 Divide SHALL operate on magnitudes.
  - Signed quotient is negated when operand signs differ.
  - Signed remainder takes the sign of a.
REQ-021 Divide by zero (b=0) SHALL give: DIV/DIVU quotient 32'hFFFFFFFF; REM/REMU remainder = a.
REQ-022 Signed overflow (DIV/REM, a=32'h80000000, b=32'hFFFFFFFF) SHALL give DIV 32'h80000000 and REM 0.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge, with no wb_we pulse; flush has priority over start.
REQ-025 rd=0 SHALL still produce the wb_we pulse; the register file discards writes to x0.
REQ-026 wb_we, wb_wa and wb_wd SHALL be registered outputs; wb_wa and wb_wd are 0 whenever wb_we=0.
REQ-027 Operands SHALL be captured at start and held internally; later changes on a/b/op/rd SHALL not affect the result.
REQ-028 Back-to-back ops: start SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, busy=0, wb_we=0, wb_wa=0, wb_wd=0, counter=0, all datapath registers 0.
REQ-030 Reset asserted mid-CALC SHALL abort the operation with no write, including after rst_n rises.
REQ-031 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 MUL a=7, b=-3 (32'hFFFFFFFD) -> wb_wd=32'hFFFFFFEB at cycle 34 (33rd edge), wb_wa=rd, busy high for 33 cycles.
REQ-033 MULH a=b=32'h80000000 -> 32'h40000000; MULHU with the same operands -> 32'h40000000; MULHSU a=-1, b=2 -> 32'hFFFFFFFF.
REQ-034 DIV a=-7, b=2 -> 32'hFFFFFFFD; REM with the same operands -> 32'hFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-035 DIVU a=5, b=0 -> 32'hFFFFFFFF in the 2nd cycle; REM a=32'h80000000, b=-1 -> 0 in the 2nd cycle.
REQ-036 start re-asserted during CALC with different operands -> first result unchanged; flush at iteration 10 -> no wb_we, busy=0 next cycle.
REQ-037 rst_n pulsed low mid-CALC -> outputs 0 asynchronously; new DIVU 9/3 after release -> 3 at cycle 34.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit.
// Multiply is a 32-step shift-add and divide is a 32-step restoring divider;
// both run on operand magnitudes and fix up the sign of the result on the
// final step, so the write-back is registered directly from the last step.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// CALC  | one iteration per cycle, iteration counter 0..31
// DONE  | single-cycle write-back pulse on wb_we/wb_wa/wb_wd
module mdu_iter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  rd,
   input  logic        flush,
   output logic        busy,
   output logic        wb_we,
   output logic [4:0]  wb_wa,
   output logic [31:0] wb_wd
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   // hi: running upper product / partial remainder
   // lo: multiplier bits being consumed / dividend shifting into quotient
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   // dvs: multiplicand magnitude or divisor magnitude
   logic [31:0] dvs_q, dvs_d;
   logic        neg_q, neg_d;
   logic        wb_we_q, wb_we_d;
   logic [4:0]  wb_wa_q, wb_wa_d;
   logic [31:0] wb_wd_q, wb_wd_d;

   // Operand decode on the incoming request
   logic        in_div, a_sgn, b_sgn, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic        div_zero, div_ovf, special;
   logic [31:0] special_res;

   assign in_div      = op[2];
   assign a_sgn       = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
   assign b_sgn       = a_sgn && (op != OP_MULHSU);
   assign a_neg       = a_sgn & a[31];
   assign b_neg       = b_sgn & b[31];
   assign a_mag       = a_neg ? (32'd0 - a) : a;
   assign b_mag       = b_neg ? (32'd0 - b) : b;
   assign div_zero    = in_div && (b == 32'd0);
   assign div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                        (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign special     = div_zero || div_ovf;
   // op[1] separates remainder from quotient among the divide ops
   assign special_res = div_zero ? (op[1] ? a : 32'hFFFF_FFFF)
                                 : (op[1] ? 32'd0 : 32'h8000_0000);

   // One iteration of the selected algorithm
   logic [32:0] mul_sum;
   logic [32:0] rem_sh;
   logic [33:0] div_diff;
   logic        div_ok;
   logic [31:0] step_hi, step_lo;

   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : 33'd0);
   assign rem_sh   = {hi_q, lo_q[31]};
   assign div_diff = {1'b0, rem_sh} - {2'b00, dvs_q};
   assign div_ok   = ~div_diff[33];
   assign step_hi  = op_q[2] ? (div_ok ? div_diff[31:0] : rem_sh[31:0]) : mul_sum[32:1];
   assign step_lo  = op_q[2] ? {lo_q[30:0], div_ok} : {mul_sum[0], lo_q[31:1]};

   // Sign fix-up applied to the outcome of the last iteration
   logic [63:0] prod, prod_s;
   logic [31:0] quo_s, rem_s, final_res;

   assign prod      = {step_hi, step_lo};
   assign prod_s    = neg_q ? (64'd0 - prod) : prod;
   assign quo_s     = neg_q ? (32'd0 - step_lo) : step_lo;
   assign rem_s     = neg_q ? (32'd0 - step_hi) : step_hi;
   assign final_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                              : ((op_q == OP_MUL) ? prod_s[31:0] : prod_s[63:32]);

   // State register and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         op_q    <= 3'd0;
         rd_q    <= 5'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         dvs_q   <= 32'd0;
         neg_q   <= 1'b0;
         wb_we_q <= 1'b0;
         wb_wa_q <= 5'd0;
         wb_wd_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dvs_q   <= dvs_d;
         neg_q   <= neg_d;
         wb_we_q <= wb_we_d;
         wb_wa_q <= wb_wa_d;
         wb_wd_q <= wb_wd_d;
      end
   end

   // Next-state, capture, iteration and write-back decisions
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dvs_d   = dvs_q;
      neg_d   = neg_q;
      wb_we_d = 1'b0;
      wb_wa_d = 5'd0;
      wb_wd_d = 32'd0;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op;
               rd_d  = rd;
               cnt_d = 5'd0;
               if (special) begin
                  wb_we_d = 1'b1;
                  wb_wa_d = rd;
                  wb_wd_d = special_res;
                  state_d = DONE;
               end else begin
                  hi_d    = 32'd0;
                  lo_d    = in_div ? a_mag : b_mag;
                  dvs_d   = in_div ? b_mag : a_mag;
                  // remainder follows the dividend; everything else the sign xor
                  neg_d   = (in_div && op[1]) ? a_neg : (a_neg ^ b_neg);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               wb_we_d = 1'b1;
               wb_wa_d = rd_q;
               wb_wd_d = final_res;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // abort wins over everything, including a request seen in IDLE
      if (flush) begin
         state_d = IDLE;
         wb_we_d = 1'b0;
         wb_wa_d = 5'd0;
         wb_wd_d = 32'd0;
      end
   end

   assign busy  = (state_q != IDLE);
   assign wb_we = wb_we_q;
   assign wb_wa = wb_wa_q;
   assign wb_wd = wb_wd_q;

endmodule
